tile_scanout: RTL and testbench
===============================

TILE_SCANOUT -- requirements
Module: tile_scanout

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 in_valid  input  1  a complete 4-tile colour block is presented on the inputs below.
REQ-004 in_ready  output  1  the block SHALL accept a colour block in this cycle.
REQ-005 reds0..reds3, greens0..greens3, blues0..blues3  input  256 each  tile t channels; pixel i (0..63) occupies bits [4i+3:4i].
REQ-006 pix_valid  output  1  pix_* outputs carry a valid pixel.
REQ-007 pix_ready  input  1  the downstream consumer accepts the pixel.
REQ-008 pix_rgb  output  12  {red, green, blue}, 4 bits each.
REQ-009 pix_tile  output  2  tile number of the current pixel.
REQ-010 pix_index  output  6  pixel index within the tile.
REQ-011 pix_last  output  1  high on tile 3, pixel 63.

Function
REQ-012 Input transfer SHALL occur when in_valid && in_ready; all 12 channel buses SHALL be captured into an internal 3072-bit buffer in that cycle.
REQ-013 Output transfer SHALL occur when pix_valid && pix_ready.
REQ-014 The FSM SHALL have exactly two states: IDLE (buffer empty) and STREAM (buffer holds a block).
REQ-015 IDLE: in_ready=1, pix_valid=0; an input transfer SHALL move to STREAM with the 8-bit pixel counter at 0.
REQ-016 STREAM: pix_valid=1; pix_tile=counter[7:6]; pix_index=counter[5:0]; pix_rgb is taken from the buffered tile pix_tile at pixel pix_index.
REQ-017 Order SHALL be tile 0 pixels 0..63, then tile 1, tile 2, tile 3: 256 pixels per block.
REQ-018 The counter SHALL increment by 1 only on an output transfer.
REQ-019 While pix_valid=1 and pix_ready=0, all pix_* outputs SHALL stay stable.
REQ-020 An output transfer at counter 255 (pix_last=1) SHALL end the block: the counter wraps to 0 and the FSM returns to IDLE, unless REQ-026 applies.
REQ-021 Latency: the first pixel SHALL be valid in the cycle after the input transfer; at most 1 pixel is transferred per cycle.
REQ-022 In STREAM, in_ready SHALL be 0 except as allowed by REQ-026, and the buffer SHALL NOT change.
REQ-023 With pix_ready held at 1, a block SHALL drain in exactly 256 consecutive cycles.
REQ-024 In IDLE, pix_rgb, pix_tile, pix_index and pix_last SHALL be 0.

Reset
REQ-025 When rst_n=0 at a clock edge, including mid-block, the block SHALL enter IDLE with counter=0, pix_valid=0, pix_rgb=0, pix_tile=0, pix_index=0 and pix_last=0; in_ready SHALL be 1 from the first cycle after reset; the rest of the block SHALL be discarded; buffer contents need not be cleared.

Configuration
REQ-026 Macro TILE_SCANOUT_PREFETCH_EN:
- Defined: in STREAM, in_ready = pix_last && pix_ready. An input transfer coincident with the final output transfer SHALL reload the buffer, keep the FSM in STREAM with counter 0, and give back-to-back blocks with no bubble.
- Undefined: in_ready SHALL be 1 only in IDLE, giving at least one idle cycle between blocks.

Verification
REQ-027 Reset, then one block with reds0[3:0]=4'hA, greens0[3:0]=4'h5, blues0[3:0]=4'h3, pix_ready=1 -> the cycle after the transfer shows pix_rgb=12'hA53, pix_tile=0, pix_index=0.
REQ-028 Block where tile t pixel i has red=i[3:0], green=t, blue=~i[3:0], pix_ready=1 -> 256 pixels in order; pixel 130 shows pix_tile=2, pix_index=2, rgb=12'h22D; pix_last only on pixel 255; IDLE on the next cycle.
REQ-029 pix_ready toggled 1,0,0,1 repeatedly -> no pixel lost or duplicated, outputs stable while stalled, counter advances only on transfers.
REQ-030 in_valid held at 1 for two blocks, pix_ready=1 -> with PREFETCH_EN, pixel 0 of block 2 in the cycle after pix_last; without it, exactly 1 cycle with pix_valid=0 between the blocks.
REQ-031 rst_n=0 for 1 cycle at counter 100 -> next cycle pix_valid=0, in_ready=1, all outputs 0; a new block then starts at pixel 0.
REQ-032 in_valid pulsed mid-stream at counter 50 with different data -> in_ready=0, the pulse is ignored, and the streamed pixels match the first block.

Source files
------------

// File: rtl/tile_scanout.sv
// Buffers one 4-tile colour block and streams it out pixel by pixel, tile 0..3, pixel 0..63.
// Optional TILE_SCANOUT_PREFETCH_EN: accept the next block on the final pixel for gapless streaming.
module tile_scanout (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] reds0,
   input  logic [255:0] reds1,
   input  logic [255:0] reds2,
   input  logic [255:0] reds3,
   input  logic [255:0] greens0,
   input  logic [255:0] greens1,
   input  logic [255:0] greens2,
   input  logic [255:0] greens3,
   input  logic [255:0] blues0,
   input  logic [255:0] blues1,
   input  logic [255:0] blues2,
   input  logic [255:0] blues3,
   output logic         pix_valid,
   input  logic         pix_ready,
   output logic [11:0]  pix_rgb,
   output logic [1:0]   pix_tile,
   output logic [5:0]   pix_index,
   output logic         pix_last
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [255:0] red_q   [4];
   logic [255:0] green_q [4];
   logic [255:0] blue_q  [4];
   logic         at_last;
   logic         in_xfer;
   logic [1:0]   tile_sel;
   logic [7:0]   bit_base;

   assign at_last  = (cnt_q == 8'hFF);
   assign in_xfer  = in_valid && in_ready;
   assign tile_sel = cnt_q[7:6];
   assign bit_base = {cnt_q[5:0], 2'b00};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      pix_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = STREAM;
               cnt_d   = 8'd0;
            end
         end
         STREAM: begin
            pix_valid = 1'b1;
`ifdef TILE_SCANOUT_PREFETCH_EN
            in_ready  = at_last && pix_ready;
`endif
            if (pix_ready) begin
               if (at_last) begin
                  cnt_d   = 8'd0;
                  // A block accepted on the final pixel keeps streaming without a bubble.
                  state_d = (in_valid && in_ready) ? STREAM : IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Buffer holds its contents through reset; only a handshake overwrites it.
   always_ff @(posedge clk) begin
      if (rst_n && in_xfer) begin
         red_q[0]   <= reds0;
         red_q[1]   <= reds1;
         red_q[2]   <= reds2;
         red_q[3]   <= reds3;
         green_q[0] <= greens0;
         green_q[1] <= greens1;
         green_q[2] <= greens2;
         green_q[3] <= greens3;
         blue_q[0]  <= blues0;
         blue_q[1]  <= blues1;
         blue_q[2]  <= blues2;
         blue_q[3]  <= blues3;
      end
   end

   always_comb begin
      pix_rgb   = 12'd0;
      pix_tile  = 2'd0;
      pix_index = 6'd0;
      pix_last  = 1'b0;
      if (state_q == STREAM) begin
         pix_tile  = tile_sel;
         pix_index = cnt_q[5:0];
         pix_last  = at_last;
         pix_rgb   = {red_q[tile_sel][bit_base +: 4],
                      green_q[tile_sel][bit_base +: 4],
                      blue_q[tile_sel][bit_base +: 4]};
      end
   end

endmodule

// File: tb/tb_tile_scanout.sv
// Randomized bench for tile_scanout with a per-cycle reference model of the pixel stream.
module tb_tile_scanout;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] r [4];
   logic [255:0] g [4];
   logic [255:0] b [4];
   logic         pix_valid;
   logic         pix_ready;
   logic [11:0]  pix_rgb;
   logic [1:0]   pix_tile;
   logic [5:0]   pix_index;
   logic         pix_last;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef TILE_SCANOUT_PREFETCH_EN
   localparam bit PREFETCH = 1'b1;
`else
   localparam bit PREFETCH = 1'b0;
`endif

   tile_scanout dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .reds0(r[0]), .reds1(r[1]), .reds2(r[2]), .reds3(r[3]),
      .greens0(g[0]), .greens1(g[1]), .greens2(g[2]), .greens3(g[3]),
      .blues0(b[0]), .blues1(b[1]), .blues2(b[2]), .blues3(b[3]),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
      .pix_tile(pix_tile), .pix_index(pix_index), .pix_last(pix_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tmo(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: got expired bound want event at %0t", name, $time);
   endtask

   // Reference model: the block currently being streamed and how many pixels have gone out.
   logic [3:0] m_r [4][64];
   logic [3:0] m_g [4][64];
   logic [3:0] m_b [4][64];
   bit m_busy = 1'b0;
   int m_pos  = 0;
   bit chk_en = 1'b0;

   always @(negedge clk) begin
      bit exp_rdy, in_x, out_x;
      int t, i;
      exp_rdy = !m_busy ? 1'b1 : (PREFETCH && m_pos == 255 && pix_ready);
      if (chk_en) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("pix_valid", {31'd0, pix_valid}, {31'd0, m_busy});
         if (m_busy) begin
            t = m_pos / 64;
            i = m_pos % 64;
            chk("pix_rgb", {20'd0, pix_rgb}, {20'd0, m_r[t][i], m_g[t][i], m_b[t][i]});
            chk("pix_tile", {30'd0, pix_tile}, t);
            chk("pix_index", {26'd0, pix_index}, i);
            chk("pix_last", {31'd0, pix_last}, {31'd0, (m_pos == 255)});
         end else begin
            chk("idle_outs", {11'd0, pix_rgb, pix_tile, pix_index, pix_last}, 32'd0);
         end
      end
      if (!rst_n) begin
         m_busy = 1'b0;
         m_pos  = 0;
         chk_en = 1'b1;
      end else begin
         in_x  = in_valid && exp_rdy;
         out_x = m_busy && pix_ready;
         if (out_x) begin
            if (m_pos == 255) begin
               m_busy = 1'b0;
               m_pos  = 0;
            end else begin
               m_pos++;
            end
         end
         if (in_x) begin
            for (int tt = 0; tt < 4; tt++)
               for (int ii = 0; ii < 64; ii++) begin
                  m_r[tt][ii] = r[tt][4*ii +: 4];
                  m_g[tt][ii] = g[tt][4*ii +: 4];
                  m_b[tt][ii] = b[tt][4*ii +: 4];
               end
            m_busy = 1'b1;
            m_pos  = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: random data; mode 1: red=i, green=t, blue=~i
   task automatic set_block(input int mode);
      for (int t = 0; t < 4; t++)
         for (int i = 0; i < 64; i++) begin
            if (mode == 1) begin
               r[t][4*i +: 4] = 4'(i);
               g[t][4*i +: 4] = 4'(t);
               b[t][4*i +: 4] = ~4'(i);
            end else begin
               r[t][4*i +: 4] = 4'($urandom);
               g[t][4*i +: 4] = 4'($urandom);
               b[t][4*i +: 4] = 4'($urandom);
            end
         end
   endtask

   task automatic drain(input bit rnd);
      int n;
      n = 0;
      while (pix_valid && n < 2000) begin
         pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         n++;
      end
      if (n >= 2000) tmo("drain");
      pix_ready = 1'b1;
      tick();
   endtask

   task automatic wait_count(input logic [7:0] target, input bit rnd);
      int n;
      n = 0;
      while (!(pix_valid && {pix_tile, pix_index} == target) && n < 2000) begin
         pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         n++;
      end
      if (n >= 2000) tmo("wait_count");
   endtask

   initial begin
      int n, gap;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      pix_ready = 1'b0;
      for (int t = 0; t < 4; t++) begin
         r[t] = '0;
         g[t] = '0;
         b[t] = '0;
      end
      repeat (2) tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      rst_n = 1'b1;
      tick();

      // First pixel appears the cycle after the handshake.
      set_block(0);
      r[0][3:0] = 4'hA;
      g[0][3:0] = 4'h5;
      b[0][3:0] = 4'h3;
      in_valid  = 1'b1;
      pix_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("first_rgb", {20'd0, pix_rgb}, 32'hA53);
      chk("first_pos", {24'd0, pix_tile, pix_index}, 32'd0);
      chk("first_valid", {31'd0, pix_valid}, 32'd1);
      drain(1'b0);

      // Patterned block at full rate drains in exactly 256 cycles.
      set_block(1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 256; k++) begin
         chk("pat_valid", {31'd0, pix_valid}, 32'd1);
         chk("pat_last", {31'd0, pix_last}, {31'd0, (k == 255)});
         if (k == 130) begin
            chk("pat130_rgb", {20'd0, pix_rgb}, 32'h22D);
            chk("pat130_tile", {30'd0, pix_tile}, 32'd2);
            chk("pat130_index", {26'd0, pix_index}, 32'd2);
         end
         tick();
      end
      chk("pat_idle_after", {31'd0, pix_valid}, 32'd0);
      tick();

      // Stall pattern 1,0,0,1.
      set_block(0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (pix_valid && n < 1200) begin
         pix_ready = (n % 4 == 0) || (n % 4 == 3);
         tick();
         n++;
      end
      if (n >= 1200) tmo("stall_drain");
      pix_ready = 1'b1;
      tick();

      // Two blocks back to back with in_valid held.
      set_block(0);
      in_valid = 1'b1;
      tick();
      set_block(0);
      n = 0;
      while (!pix_last && n < 400) begin tick(); n++; end
      if (n >= 400) tmo("b2b_last");
      tick();
      gap = 0;
      while (!pix_valid && gap < 5) begin gap++; tick(); end
      in_valid = 1'b0;
      chk("b2b_gap", gap, PREFETCH ? 32'd0 : 32'd1);
      chk("b2b_pos0", {24'd0, pix_tile, pix_index}, 32'd0);
      drain(1'b0);

      // Reset mid-block at counter 100.
      set_block(0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_count(8'd100, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_outs", {11'd0, pix_rgb, pix_tile, pix_index, pix_last}, 32'd0);
      set_block(0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_rst_valid", {31'd0, pix_valid}, 32'd1);
      chk("post_rst_pos", {24'd0, pix_tile, pix_index}, 32'd0);
      drain(1'b1);

      // A mid-stream offer at counter 50 must be refused.
      set_block(0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_count(8'd50, 1'b1);
      set_block(0);
      in_valid = 1'b1;
      chk("mid_offer_ready", {31'd0, in_ready}, 32'd0);
      tick();
      in_valid = 1'b0;
      drain(1'b1);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) == 0);
         pix_ready = ($urandom_range(0, 3) != 0);
         if (in_valid) set_block(0);
         tick();
      end
      in_valid = 1'b0;
      drain(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
